// File: rtl/param_timer_pkg.sv
// ---------------------------------------------------------------------------
// param_timer_pkg
//   Shared types and helpers for the programmable timers.
//   - timer_state_t : two-state timer FSM encoding (IDLE / RUN)
//   - clamp_load    : saturates a requested load value to the legal range
//                     0..mod-1 so an oversized request still gives the
//                     longest legal delay instead of wrapping.
// ---------------------------------------------------------------------------
package param_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_t;

    function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                               input logic [31:0] mod);
        return (val > (mod - 32'd1)) ? (mod - 32'd1) : val;
    endfunction

endpackage

// File: rtl/param_down_timer.sv
// ---------------------------------------------------------------------------
// param_down_timer
//   Loadable modulo down-counter used as a one-shot delay/timeout.
//   A start request in IDLE loads a (clamped) count, the counter steps down
//   once per clock, and o_done pulses for the single cycle the count shows 0.
//
//   Optional build macro: PARAM_DOWN_TIMER_RELOAD_EN
//     defined   - periodic mode: at zero the latched load value is reloaded
//                 and the timer stays in RUN (period L+1); leave via abort
//                 or reset only.
//     undefined - one-shot mode: return to IDLE after the done cycle.
// ---------------------------------------------------------------------------
module param_down_timer
    import param_timer_pkg::*;
#(
    parameter  int MOD = 100000,
    localparam int W   = $clog2(MOD) + 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_load_val,
    input  logic         i_pause,
    input  logic         i_abort,
    output logic [W-1:0] o_count,
    output logic         o_busy,
    output logic         o_done
);

    timer_state_t state_reg, state_next;
    logic [W-1:0] count_reg, count_next;
    logic [W-1:0] load_reg,  load_next;
    logic         done_reg,  done_next;
    logic [W-1:0] load_clamped;

    assign load_clamped = W'(clamp_load(32'(i_load_val), 32'(MOD)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            load_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            load_reg  <= load_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        load_next  = load_reg;

        if (i_abort) begin
            state_next = ST_IDLE;
            count_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        load_next  = load_clamped;
                        count_next = load_clamped;
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Terminal count wins over pause: zero always moves on.
                    if (count_reg == '0) begin
`ifdef PARAM_DOWN_TIMER_RELOAD_EN
                        count_next = load_reg;
`else
                        state_next = ST_IDLE;
`endif
                    end else if (!i_pause) begin
                        count_next = count_reg - W'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end
            endcase
        end

        // Done is registered alongside the count so it is high exactly in
        // the cycle where the registered state is RUN with count zero.
        done_next = (state_next == ST_RUN) && (count_next == '0);
    end

    assign o_count = count_reg;
    assign o_busy  = (state_reg == ST_RUN);
    assign o_done  = done_reg;

endmodule

// File: tb/tb_param_down_timer.sv
module tb_param_down_timer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [17:0] load_val;
    logic        pause;
    logic        abort;
    logic [17:0] count;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    param_down_timer #(.MOD(100000)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_load_val (load_val),
        .i_pause    (pause),
        .i_abort    (abort),
        .o_count    (count),
        .o_busy     (busy),
        .o_done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int c, input int b, input int d);
        check({tag, "_count"}, 32'(count), 32'(c));
        check({tag, "_busy"},  32'(busy),  32'(b));
        check({tag, "_done"},  32'(done),  32'(d));
    endtask

    task automatic do_start(input int l);
        start    = 1'b1;
        load_val = 18'(l);
        step();
        start    = 1'b0;
        $display("start load=%0d count=%0d busy=%0d", l, count, busy);
    endtask

    // Expected counts for L=10 with pause held during cycles 5..7.
    int pause_exp [14] = '{10, 9, 8, 7, 6, 6, 6, 6, 5, 4, 3, 2, 1, 0};

    initial begin
        rst_n    = 1'b0;
        start    = 1'b1;
        load_val = 18'd7;
        pause    = 1'b0;
        abort    = 1'b0;

        // 1: reset held with start asserted
        #5;
        check_out("rst_t5", 0, 0, 0);
        #7;
        check_out("rst_t12", 0, 0, 0);
        #3 rst_n = 1'b1;
        start = 1'b0;
        step();
        check_out("post_rst", 0, 0, 0);
        $display("reset released");

        // 2: L=5, counts 5..0, done only at 0, then IDLE
        do_start(5);
        for (int k = 0; k < 6; k++) begin
            check_out($sformatf("l5_c%0d", k), 5 - k, 1, (k == 5) ? 1 : 0);
            step();
        end
        check_out("l5_idle", 0, 0, 0);
        $display("L=5 run complete");

        // 3: L=0 done one cycle after start; oversize load clamps
        do_start(0);
        check_out("l0_done", 0, 1, 1);
        step();
        check_out("l0_idle", 0, 0, 0);

        do_start(200000);
        check_out("clamp", 99999, 1, 0);
        step();
        check("clamp_dec", 32'(count), 32'd99998);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_out("clamp_abort", 0, 0, 0);
        $display("L=0 and clamp done");

        // 4: pause at count 6 for three cycles, done on 14th cycle
        do_start(10);
        for (int c = 1; c <= 14; c++) begin
            check_out($sformatf("pause_c%0d", c), pause_exp[c-1], 1, (c == 14) ? 1 : 0);
            pause = (c >= 5 && c <= 7) ? 1'b1 : 1'b0;
            step();
        end
        pause = 1'b0;
        check_out("pause_idle", 0, 0, 0);
        $display("pause run complete");

        // 5: start during RUN ignored, abort at count 4
        do_start(10);
        check_out("ab_c1", 10, 1, 0);
        start    = 1'b1;
        load_val = 18'd2;
        step();
        start    = 1'b0;
        check_out("ab_ign", 9, 1, 0);
        for (int c = 3; c <= 7; c++) step();
        check_out("ab_c4", 4, 1, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_out("ab_after", 0, 0, 0);
        step();
        check_out("ab_idle", 0, 0, 0);
        $display("abort run complete");

        // abort in the terminal cycle: done already visible, nothing more
        do_start(1);
        step();
        check_out("abterm_c0", 0, 1, 1);
        abort = 1'b1;
        pause = 1'b1;
        step();
        abort = 1'b0;
        pause = 1'b0;
        check_out("abterm_after", 0, 0, 0);

`ifdef PARAM_DOWN_TIMER_RELOAD_EN
        // 6: periodic mode, L=3 -> done every 4 cycles, 5 pulses
        do_start(3);
        for (int c = 1; c <= 20; c++) begin
            check_out($sformatf("rl_c%0d", c), 3 - ((c - 1) % 4), 1,
                      (((c - 1) % 4) == 3) ? 1 : 0);
            step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_out("rl_abort", 0, 0, 0);
        $display("reload run complete");
`else
        // one-shot: no second pulse after done
        do_start(3);
        for (int c = 0; c < 3; c++) step();
        check_out("os_done", 0, 1, 1);
        step();
        check_out("os_idle", 0, 0, 0);
        step();
        check_out("os_stay", 0, 0, 0);
        $display("one-shot run complete");
`endif

        // async reset mid-RUN clears outputs without a clock edge
        do_start(20);
        step();
        step();
        check_out("ar_run", 18, 1, 0);
        #4 rst_n = 1'b0;
        #1;
        check_out("ar_async", 0, 0, 0);
        #2 rst_n = 1'b1;
        step();
        check_out("ar_after", 0, 0, 0);
        $display("async reset complete");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
